// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter (T1..T6) plus the
// control-matrix decode producing the 12-bit control word and a sticky halt flag.
module sap1_controller_sequencer #(
  parameter logic [3:0] LDA_OP = 4'h0,
  parameter logic [3:0] ADD_OP = 4'h1,
  parameter logic [3:0] SUB_OP = 4'h2,
  parameter logic [3:0] OUT_OP = 4'hE,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic [3:0]  OPCODE,
  output logic [5:0]  T,
  output logic [11:0] CON,
  output logic        HLT
);

  // Control word bit order: Cp Ep LM_N CE_N LI_N EI_N LA_N Ea Su Eu LB_N LO_N
  localparam logic [11:0] ConIdle  = 12'h3E3;
  localparam logic [11:0] ConT1    = 12'h5E3;
  localparam logic [11:0] ConT2    = 12'hBE3;
  localparam logic [11:0] ConT3    = 12'h263;
  localparam logic [11:0] ConIrMar = 12'h1A3;
  localparam logic [11:0] ConLda5  = 12'h2C3;
  localparam logic [11:0] ConAlu5  = 12'h2E1;
  localparam logic [11:0] ConAdd6  = 12'h3C7;
  localparam logic [11:0] ConSub6  = 12'h3CF;
  localparam logic [11:0] ConOut4  = 12'h3F2;

  typedef enum logic [5:0] {
    StT1 = 6'b000001,
    StT2 = 6'b000010,
    StT3 = 6'b000100,
    StT4 = 6'b001000,
    StT5 = 6'b010000,
    StT6 = 6'b100000
  } state_e;

  state_e state_q, state_d;
  logic   halt_q, halt_d;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StT1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    halt_d  = HLT;
    state_d = StT1;
    if (halt_d && (state_q == StT4)) begin
      state_d = StT4;
    end else begin
      case (state_q)
        StT1:    state_d = StT2;
        StT2:    state_d = StT3;
        StT3:    state_d = StT4;
        StT4:    state_d = StT5;
        StT5:    state_d = StT6;
        StT6:    state_d = StT1;
        // Any non-one-hot encoding falls back to T1.
        default: state_d = StT1;
      endcase
    end
  end

  always_comb begin
    T   = state_q;
    HLT = halt_q | ((state_q == StT4) && (OPCODE == HLT_OP));
    CON = ConIdle;
    if (CLR_N && !HLT) begin
      case (state_q)
        StT1: CON = ConT1;
        StT2: CON = ConT2;
        StT3: CON = ConT3;
        StT4: begin
          case (OPCODE)
            LDA_OP, ADD_OP, SUB_OP: CON = ConIrMar;
            OUT_OP:                 CON = ConOut4;
            default:                CON = ConIdle;
          endcase
        end
        StT5: begin
          case (OPCODE)
            LDA_OP:         CON = ConLda5;
            ADD_OP, SUB_OP: CON = ConAlu5;
            default:        CON = ConIdle;
          endcase
        end
        StT6: begin
          case (OPCODE)
            ADD_OP:  CON = ConAdd6;
            SUB_OP:  CON = ConSub6;
            default: CON = ConIdle;
          endcase
        end
        default: CON = ConIdle;
      endcase
    end
  end

endmodule
